// File: rtl/mc_pkg.sv
// mc_pkg - shared definitions for the multicycle_ctrl block.
//   state_t      : controller FSM states
//   alu_op_t     : ALU operation class handed to mc_alu_dec
//   OP_*         : opcode values (zero-extended to the opcode width)
//   ALU_*        : alucontrol encodings
//   SRCB_* / PC_*: alusrcb and pcsrc mux encodings
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_REG_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_FUNC
  } alu_op_t;

  localparam int OP_RTYPE = 0;
  localparam int OP_ADDI  = 1;
  localparam int OP_LW    = 2;
  localparam int OP_SW    = 3;
  localparam int OP_BEQ   = 4;
  localparam int OP_BNE   = 5;
  localparam int OP_JUMP  = 6;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec - ALU control decoder for multicycle_ctrl.
//   alu_op     in  : operation class chosen by the controller state
//   func       in  : instruction function field; only func[4:0] matters
//   alucontrol out : ALU operation select (see ALU_* in mc_pkg)
// For register-type operations the lowest set bit of func[4:0] wins;
// with none of those bits set the ALU adds.
module mc_alu_dec
  import mc_pkg::*;
#(
  parameter int FNW = 9
) (
  input  alu_op_t        alu_op,
  input  logic [FNW-1:0] func,
  output logic [2:0]     alucontrol
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives the
    // output and no latch is inferred.
    alucontrol = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB: alucontrol = ALU_SUB;
      ALU_OP_FUNC: begin
        if (func[0])      alucontrol = ALU_ADD;
        else if (func[1]) alucontrol = ALU_SUB;
        else if (func[2]) alucontrol = ALU_AND;
        else if (func[3]) alucontrol = ALU_OR;
        else if (func[4]) alucontrol = ALU_SLT;
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

  // Upper function bits carry no ALU meaning for this controller.
  if (FNW > 5) begin : g_func_hi
    logic unused_func_hi;
    assign unused_func_hi = ^func[FNW-1:5];
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl - multi-cycle instruction controller with memory handshake.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, waits on mem_ready with a
// bounded timeout (bus_err), and traps undefined opcodes (illegal).
// Optional build macro: MC_PERF_CNT_EN adds cyc_cnt / ret_cnt counters.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   opcode, func    : instruction fields from the IR (held for the instruction)
//   zero            : ALU zero flag
//   mem_ready       : memory finishes the current access this cycle
//   mem_req         : memory access request
//   pwrite, iwrite, regwrite, memwrite : write enables
//   adrsrc, memtoreg, alusrca, regdest : 1-bit mux selects
//   alusrcb, pcsrc, alucontrol          : multi-bit selects
//   illegal, bus_err                    : one-cycle fault pulses
//   cyc_cnt, ret_cnt (MC_PERF_CNT_EN)   : cycle and retired-instruction counts
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int FNW      = 9,
  parameter int MAX_WAIT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] func,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           pwrite,
  output logic           iwrite,
  output logic           regwrite,
  output logic           memwrite,
  output logic           adrsrc,
  output logic           memtoreg,
  output logic           alusrca,
  output logic           regdest,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [2:0]     alucontrol,
  output logic           illegal,
  output logic           bus_err
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]    cyc_cnt,
  output logic [31:0]    ret_cnt
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  alu_op_t       alu_op;
  logic          in_mem_state, timeout;
  logic          op_rtype, op_addi, op_lw, op_sw, op_beq, op_bne, op_jump;

  assign op_rtype = (opcode == OPW'(OP_RTYPE));
  assign op_addi  = (opcode == OPW'(OP_ADDI));
  assign op_lw    = (opcode == OPW'(OP_LW));
  assign op_sw    = (opcode == OPW'(OP_SW));
  assign op_beq   = (opcode == OPW'(OP_BEQ));
  assign op_bne   = (opcode == OPW'(OP_BNE));
  assign op_jump  = (opcode == OPW'(OP_JUMP));

  assign in_mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // A ready in the last allowed cycle still completes the access.
  assign timeout = in_mem_state && !mem_ready && (wait_cnt == WAIT_LIMIT);

  mc_alu_dec #(.FNW(FNW)) u_alu_dec (
    .alu_op     (alu_op),
    .func       (func),
    .alucontrol (alucontrol)
  );

  always_comb begin
    next_state = state;
    alu_op     = ALU_OP_ADD;
    mem_req    = 1'b0;
    pwrite     = 1'b0;
    iwrite     = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    adrsrc     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    regdest    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PC_ALU;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    // Every output stays at 0 while reset is held.
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = SRCB_ONE;
          if (timeout) begin
            bus_err = 1'b1;
          end else if (mem_ready) begin
            iwrite     = 1'b1;
            pwrite     = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          // Branch target is computed here and parked in ALUOut.
          alusrcb = SRCB_IMM;
          if (op_rtype)             next_state = S_EXEC_R;
          else if (op_addi)         next_state = S_EXEC_I;
          else if (op_lw || op_sw)  next_state = S_MEM_ADDR;
          else if (op_beq || op_bne) next_state = S_BRANCH;
          else if (op_jump)         next_state = S_JUMP;
          else begin
            illegal    = 1'b1;
            next_state = S_FETCH;
          end
        end
        S_EXEC_R: begin
          alusrca    = 1'b1;
          alu_op     = ALU_OP_FUNC;
          next_state = S_REG_WB;
        end
        S_EXEC_I: begin
          alusrcb    = SRCB_IMM;
          next_state = S_REG_WB;
        end
        S_REG_WB: begin
          // Shared by RTYPE and ADDI; the held opcode picks the destination.
          regwrite   = 1'b1;
          regdest    = op_rtype;
          next_state = S_FETCH;
        end
        S_MEM_ADDR: begin
          alusrca    = 1'b1;
          alusrcb    = SRCB_IMM;
          next_state = op_lw ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          adrsrc  = 1'b1;
          if (timeout) begin
            bus_err    = 1'b1;
            next_state = S_FETCH;
          end else if (mem_ready) begin
            next_state = S_MEM_WB;
          end
        end
        S_MEM_WB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          next_state = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          adrsrc  = 1'b1;
          if (timeout) begin
            bus_err    = 1'b1;
            next_state = S_FETCH;
          end else begin
            memwrite = 1'b1;
            if (mem_ready) next_state = S_FETCH;
          end
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          alu_op     = ALU_OP_SUB;
          pcsrc      = PC_ALUOUT;
          pwrite     = op_bne ? ~zero : zero;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          pcsrc      = PC_JUMP;
          pwrite     = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      // Counts only stalled cycles of a live access; any completion, timeout
      // or non-memory state clears it, so each new access starts at zero.
      if (in_mem_state && !mem_ready && !timeout) wait_cnt <= wait_cnt + CW'(1);
      else                                         wait_cnt <= '0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic ret_inc;

  // Arrivals in FETCH retire an instruction unless it was trapped or aborted.
  assign ret_inc = (next_state == S_FETCH) && (state != S_FETCH) && !illegal && !bus_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (ret_inc) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl - directed self-checking bench for multicycle_ctrl.
// Each cycle drives mem_ready/zero just after the rising edge and compares
// the full control word on the falling edge against hand-written values.
// With MC_PERF_CNT_EN defined the performance counters are checked too.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic [8:0] func;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, pwrite, iwrite, regwrite, memwrite;
  logic       adrsrc, memtoreg, alusrca, regdest;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal, bus_err;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  multicycle_ctrl #(.OPW(4), .FNW(9), .MAX_WAIT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func       (func),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .pwrite     (pwrite),
    .iwrite     (iwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .adrsrc     (adrsrc),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .regdest    (regdest),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .bus_err    (bus_err)
`ifdef MC_PERF_CNT_EN
    ,
    .cyc_cnt    (cyc_cnt),
    .ret_cnt    (ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       pwrite;
    logic       iwrite;
    logic       regwrite;
    logic       memwrite;
    logic       adrsrc;
    logic       memtoreg;
    logic       alusrca;
    logic       regdest;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic       bus_err;
  } ctl_t;

  ctl_t act;
  assign act = {mem_req, pwrite, iwrite, regwrite, memwrite, adrsrc, memtoreg,
                alusrca, regdest, alusrcb, pcsrc, alucontrol, illegal, bus_err};

  localparam ctl_t E_ZERO    = '0;
  localparam ctl_t E_F_WAIT  = '{mem_req:1'b1, alusrcb:2'b01, default:'0};
  localparam ctl_t E_F_GO    = '{mem_req:1'b1, pwrite:1'b1, iwrite:1'b1, alusrcb:2'b01, default:'0};
  localparam ctl_t E_F_TO    = '{mem_req:1'b1, alusrcb:2'b01, bus_err:1'b1, default:'0};
  localparam ctl_t E_DEC     = '{alusrcb:2'b10, default:'0};
  localparam ctl_t E_DEC_ILL = '{alusrcb:2'b10, illegal:1'b1, default:'0};
  localparam ctl_t E_EXEC_R  = '{alusrca:1'b1, default:'0};
  localparam ctl_t E_WB_R    = '{regwrite:1'b1, regdest:1'b1, default:'0};
  localparam ctl_t E_EXEC_I  = '{alusrcb:2'b10, default:'0};
  localparam ctl_t E_WB_I    = '{regwrite:1'b1, default:'0};
  localparam ctl_t E_MADDR   = '{alusrca:1'b1, alusrcb:2'b10, default:'0};
  localparam ctl_t E_MRD     = '{mem_req:1'b1, adrsrc:1'b1, default:'0};
  localparam ctl_t E_MWB     = '{regwrite:1'b1, memtoreg:1'b1, default:'0};
  localparam ctl_t E_MWR     = '{mem_req:1'b1, memwrite:1'b1, adrsrc:1'b1, default:'0};
  localparam ctl_t E_MWR_TO  = '{mem_req:1'b1, adrsrc:1'b1, bus_err:1'b1, default:'0};
  localparam ctl_t E_BR      = '{alusrca:1'b1, pcsrc:2'b01, alucontrol:3'b001, default:'0};
  localparam ctl_t E_JUMP    = '{pwrite:1'b1, pcsrc:2'b10, default:'0};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive handshake inputs, compare mid-cycle, advance.
  task automatic cyc(input string tag, input logic rdy, input logic z, input ctl_t e);
    mem_ready = rdy;
    zero      = z;
    @(negedge clk);
    check(tag, 32'(act), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic run_rtype(input string tag, input logic [8:0] f, input logic [2:0] ac);
    ctl_t e;
    e = E_EXEC_R;
    e.alucontrol = ac;
    opcode = 4'd0;
    func   = f;
    cyc({tag, "_fetch"}, 1'b1, 1'b0, E_F_GO);
    cyc({tag, "_decode"}, 1'b1, 1'b0, E_DEC);
    cyc({tag, "_exec"}, 1'b1, 1'b0, e);
    cyc({tag, "_wb"}, 1'b1, 1'b0, E_WB_R);
  endtask

  task automatic run_branch(input string tag, input logic [3:0] op, input logic z, input logic p);
    ctl_t e;
    e = E_BR;
    e.pwrite = p;
    opcode = op;
    cyc({tag, "_fetch"}, 1'b1, z, E_F_GO);
    cyc({tag, "_decode"}, 1'b1, z, E_DEC);
    cyc({tag, "_branch"}, 1'b1, z, e);
  endtask

  task automatic run_jump(input string tag);
    opcode = 4'd6;
    cyc({tag, "_fetch"}, 1'b1, 1'b0, E_F_GO);
    cyc({tag, "_decode"}, 1'b1, 1'b0, E_DEC);
    cyc({tag, "_jump"}, 1'b1, 1'b0, E_JUMP);
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 4'd0;
    func      = 9'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset_outputs", 1'b1, 1'b1, E_ZERO);
    rst = 1'b0;
`ifdef MC_PERF_CNT_EN
    check("perf_cyc_after_reset", cyc_cnt, 32'd0);
    check("perf_ret_after_reset", ret_cnt, 32'd0);
`endif

    // RTYPE sub: four cycles, regdest+regwrite in the last.
    run_rtype("r_sub", 9'h002, 3'b001);
`ifdef MC_PERF_CNT_EN
    check("perf_cyc_one_instr", cyc_cnt, 32'd4);
    check("perf_ret_one_instr", ret_cnt, 32'd1);
`endif
    // func priority: lowest set bit of func[4:0]; upper bits ignored.
    run_rtype("r_none", 9'h000, 3'b000);
    run_rtype("r_and", 9'h00C, 3'b010);
    run_rtype("r_or", 9'h008, 3'b011);
    run_rtype("r_slt", 9'h1F0, 3'b100);
    run_rtype("r_hi_only", 9'h1E0, 3'b000);
    run_rtype("r_add_over_sub", 9'h003, 3'b000);

    // ADDI
    opcode = 4'd1;
    cyc("addi_fetch", 1'b1, 1'b0, E_F_GO);
    cyc("addi_decode", 1'b1, 1'b0, E_DEC);
    cyc("addi_exec", 1'b1, 1'b0, E_EXEC_I);
    cyc("addi_wb", 1'b1, 1'b0, E_WB_I);

    // LW with three data wait cycles: eight cycles total.
    opcode = 4'd2;
    cyc("lw_fetch", 1'b1, 1'b0, E_F_GO);
    cyc("lw_decode", 1'b1, 1'b0, E_DEC);
    cyc("lw_addr", 1'b1, 1'b0, E_MADDR);
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 1'b0, 1'b0, E_MRD);
    cyc("lw_rd_done", 1'b1, 1'b0, E_MRD);
    cyc("lw_wb", 1'b1, 1'b0, E_MWB);

    // SW, zero wait.
    opcode = 4'd3;
    cyc("sw_fetch", 1'b1, 1'b0, E_F_GO);
    cyc("sw_decode", 1'b1, 1'b0, E_DEC);
    cyc("sw_addr", 1'b1, 1'b0, E_MADDR);
    cyc("sw_wr", 1'b1, 1'b0, E_MWR);

    // Branches.
    run_branch("beq_z1", 4'd4, 1'b1, 1'b1);
    run_branch("beq_z0", 4'd4, 1'b0, 1'b0);
    run_branch("bne_z1", 4'd5, 1'b1, 1'b0);
    run_branch("bne_z0", 4'd5, 1'b0, 1'b1);

    run_jump("jump");

    // Illegal opcodes trap in DECODE and return to FETCH.
    opcode = 4'hF;
    cyc("ill_f_fetch", 1'b1, 1'b0, E_F_GO);
    cyc("ill_f_decode", 1'b1, 1'b0, E_DEC_ILL);
    opcode = 4'h7;
    cyc("ill_7_fetch", 1'b1, 1'b0, E_F_GO);
    cyc("ill_7_decode", 1'b1, 1'b0, E_DEC_ILL);

    // Fetch with two wait cycles.
    opcode = 4'd6;
    cyc("fw_wait", 1'b0, 1'b0, E_F_WAIT);
    cyc("fw_wait", 1'b0, 1'b0, E_F_WAIT);
    run_jump("fw_jump");

    // SW timeout: bus_err on the 16th MEM_WR cycle, then a fresh fetch.
    opcode = 4'd3;
    cyc("swto_fetch", 1'b1, 1'b0, E_F_GO);
    cyc("swto_decode", 1'b1, 1'b0, E_DEC);
    cyc("swto_addr", 1'b1, 1'b0, E_MADDR);
    for (int i = 0; i < 15; i++) cyc("swto_wait", 1'b0, 1'b0, E_MWR);
    cyc("swto_timeout", 1'b0, 1'b0, E_MWR_TO);
    cyc("swto_refetch", 1'b1, 1'b0, E_F_GO);
    cyc("swto_decode2", 1'b1, 1'b0, E_DEC);
    cyc("swto_addr2", 1'b1, 1'b0, E_MADDR);
    cyc("swto_wr2", 1'b1, 1'b0, E_MWR);

    // Ready in the would-be timeout cycle completes the store normally.
    cyc("swlast_fetch", 1'b1, 1'b0, E_F_GO);
    cyc("swlast_decode", 1'b1, 1'b0, E_DEC);
    cyc("swlast_addr", 1'b1, 1'b0, E_MADDR);
    for (int i = 0; i < 15; i++) cyc("swlast_wait", 1'b0, 1'b0, E_MWR);
    cyc("swlast_done", 1'b1, 1'b0, E_MWR);
    run_jump("swlast_next");

    // Fetch timeout: no IR/PC write, fetch retried.
    opcode = 4'd6;
    for (int i = 0; i < 15; i++) cyc("fto_wait", 1'b0, 1'b0, E_F_WAIT);
    cyc("fto_timeout", 1'b0, 1'b0, E_F_TO);
    run_jump("fto_retry");

    // Reset during a store wait aborts it with everything low.
    opcode = 4'd3;
    cyc("rstmid_fetch", 1'b1, 1'b0, E_F_GO);
    cyc("rstmid_decode", 1'b1, 1'b0, E_DEC);
    cyc("rstmid_addr", 1'b1, 1'b0, E_MADDR);
    for (int i = 0; i < 3; i++) cyc("rstmid_wait", 1'b0, 1'b0, E_MWR);
    rst = 1'b1;
    cyc("rstmid_outputs", 1'b0, 1'b0, E_ZERO);
    rst = 1'b0;
`ifdef MC_PERF_CNT_EN
    check("perf_cyc_mid_reset", cyc_cnt, 32'd0);
    check("perf_ret_mid_reset", ret_cnt, 32'd0);
`endif
    run_jump("rstmid_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
